armleocpu_decode: RTL
=====================

// Module: armleocpu_decode
// PURPOSE
//  Single-entry decode stage between fetch and execute. Captures each fetched
//  instruction (or fetch-side exception marker) into a pipeline register and
//  decodes it: one-hot opcode class, register indices, 32-bit immediate and
//  illegal-instruction flag. Valid/ready handshake to execute; backpressure to
//  fetch via d2f_ready. Execute may kill the held entry on redirect/flush.
// PARAMETERS
//  ENABLE_M  1  1: accept OP funct7=0000001 (MUL/DIV); 0: flag illegal
// PORTS
//  clk                 in   1   clock
//  rst_n               in   1   synchronous reset, active-low
//  f2e_ignore_instr    in   1   1: fetch slot carries no instruction
//  f2e_instr           in   32  fetched instruction
//  f2e_pc              in   32  PC of f2e_instr
//  f2e_exc_start       in   1   fetch-side exception/interrupt marker
//  f2e_epc             in   32  exception PC
//  f2e_cause           in   32  exception cause
//  f2e_exc_privilege   in   2   target privilege
//  d2f_ready           out  1   decode can accept this cycle
//  e2d_kill            in   1   drop held entry and this cycle's input
//  d2e_valid           out  1   held entry valid
//  d2e_ready           in   1   execute consumes held entry
//  d2e_pc / d2e_instr  out  32  held PC / instruction
//  d2e_exc_start       out  1   held entry is an exception marker
//  d2e_epc / d2e_cause out  32  held exception PC / cause
//  d2e_exc_privilege   out  2   held target privilege
//  d2e_class           out  11  one-hot: LUI,AUIPC,JAL,JALR,BRANCH,LOAD,STORE,OPIMM,OP,MISCMEM,SYSTEM (bit0=LUI)
//  d2e_rd/rs1/rs2      out  5   instr[11:7] / [19:15] / [24:20]
//  d2e_funct3          out  3   instr[14:12]
//  d2e_imm             out  32  sign-extended immediate per format
//  d2e_illegal         out  1   held instruction is illegal
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): d2e_valid=0; all held fields cleared to 0.
//    Reset mid-operation discards held entry. Decoded outputs follow held regs.
//  - d2f_ready = !d2e_valid || d2e_ready (combinational; no skid entry).
//  - Input present = !f2e_ignore_instr || f2e_exc_start.
//  - Load: present && d2f_ready && !e2d_kill -> capture at next edge, valid=1.
//    Consume and load in the same cycle: back-to-back, one instr/cycle, no gap.
//  - d2e_ready && !load -> valid=0. Held entry stable while valid && !d2e_ready.
//  - e2d_kill: highest priority after reset; valid=0 next cycle; input dropped.
//  - Latency: input captured at edge N -> visible on d2e_* in cycle N+1.
//  - Exception marker entry: d2e_exc_start=1, epc/cause/priv captured,
//    d2e_instr=0x00000013 (NOP), d2e_class=0, d2e_illegal=0.
//  - Class from opcode instr[6:0]: 0110111,0010111,1101111,1100111,1100011,
//    0000011,0100011,0010011,0110011,0001111,1110011; none matches -> class=0.
//  - Illegal when instr[1:0]!=2'b11, class=0, JALR funct3!=0, BRANCH funct3 in
//    {2,3}, LOAD funct3 in {3,6,7}, STORE funct3>2, OPIMM SLLI funct7!=0,
//    OPIMM SRLI/SRAI funct7 not in {0,0x20}, OP funct7 not in {0,0x20,0x01},
//    OP funct7=0x20 with funct3 not in {0,5}, funct7=0x01 with ENABLE_M=0.
//  - Immediate (arith on 32 bits, bit31 sign-extended):
//    I (JALR,LOAD,OPIMM,SYSTEM): {{20{i[31]}},i[31:20]}
//    S: {{20{i[31]}},i[31:25],i[11:7]}; B: {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}
//    U: {i[31:12],12'b0}; J: {{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}
//    OP, MISCMEM, illegal/none: 0.
// TESTING
//  - Reset, then 0x00500093 (ADDI x1,x0,5) with d2e_ready=1 -> next cycle
//    valid=1, class=OPIMM, rd=1, rs1=0, imm=5, illegal=0.
//  - 0xFE000EE3 (BEQ imm=-4) while d2e_ready=0 for 3 cycles -> entry held,
//    d2f_ready=0, imm=0xFFFFFFFC; second input not captured until ready=1.
//  - Stream 4 instrs, d2e_ready=1 -> 4 consecutive valid cycles, PCs +4 each.
//  - e2d_kill with held entry and new input same cycle -> valid=0 next cycle.
//  - f2e_exc_start=1, cause=1, epc=0x2000 -> d2e_exc_start=1, cause=1,
//    instr=0x13, illegal=0; 0x00000000 and 0x4200D033 -> illegal=1.
//  - ENABLE_M=0: 0x02208033 (MUL) -> illegal=1; ENABLE_M=1 -> class=OP, illegal=0.

Source files
------------

// File: rtl/armleocpu_decode.sv
// Single-entry decode stage: captures a fetched instruction or exception marker
// and holds its decoded fields until execute consumes them or kills the entry.
module armleocpu_decode #(
  parameter bit ENABLE_M = 1'b1,
  localparam int unsigned XLEN  = 32,
  localparam int unsigned CLS_W = 11,
  localparam int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f2e_ignore_instr,
  input  logic [XLEN-1:0]  f2e_instr,
  input  logic [XLEN-1:0]  f2e_pc,
  input  logic             f2e_exc_start,
  input  logic [XLEN-1:0]  f2e_epc,
  input  logic [XLEN-1:0]  f2e_cause,
  input  logic [1:0]       f2e_exc_privilege,
  output logic             d2f_ready,
  input  logic             e2d_kill,
  output logic             d2e_valid,
  input  logic             d2e_ready,
  output logic [XLEN-1:0]  d2e_pc,
  output logic [XLEN-1:0]  d2e_instr,
  output logic             d2e_exc_start,
  output logic [XLEN-1:0]  d2e_epc,
  output logic [XLEN-1:0]  d2e_cause,
  output logic [1:0]       d2e_exc_privilege,
  output logic [CLS_W-1:0] d2e_class,
  output logic [REG_W-1:0] d2e_rd,
  output logic [REG_W-1:0] d2e_rs1,
  output logic [REG_W-1:0] d2e_rs2,
  output logic [2:0]       d2e_funct3,
  output logic [XLEN-1:0]  d2e_imm,
  output logic             d2e_illegal
);

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  localparam int unsigned C_LUI     = 0;
  localparam int unsigned C_AUIPC   = 1;
  localparam int unsigned C_JAL     = 2;
  localparam int unsigned C_JALR    = 3;
  localparam int unsigned C_BRANCH  = 4;
  localparam int unsigned C_LOAD    = 5;
  localparam int unsigned C_STORE   = 6;
  localparam int unsigned C_OPIMM   = 7;
  localparam int unsigned C_OP      = 8;
  localparam int unsigned C_MISCMEM = 9;
  localparam int unsigned C_SYSTEM  = 10;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  logic             r_valid;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_instr;
  logic             r_exc;
  logic [XLEN-1:0]  r_epc;
  logic [XLEN-1:0]  r_cause;
  logic [1:0]       r_priv;
  logic [CLS_W-1:0] r_cls;
  logic [REG_W-1:0] r_rd;
  logic [REG_W-1:0] r_rs1;
  logic [REG_W-1:0] r_rs2;
  logic [2:0]       r_f3;
  logic [XLEN-1:0]  r_imm;
  logic             r_ill;

  logic             w_present;
  logic             w_ready;
  logic             w_load;
  logic [XLEN-1:0]  w_instr;
  logic [6:0]       w_opcode;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  logic [CLS_W-1:0] w_cls;
  logic [XLEN-1:0]  w_imm;
  logic             w_ill;

  assign w_present = !f2e_ignore_instr || f2e_exc_start;
  assign w_ready   = !r_valid || d2e_ready;
  assign w_load    = w_present && w_ready && !e2d_kill;
  assign d2f_ready = w_ready;

  // Exception markers travel as a NOP so execute sees harmless register fields
  assign w_instr  = f2e_exc_start ? NOP : f2e_instr;
  assign w_opcode = w_instr[6:0];
  assign w_f3     = w_instr[14:12];
  assign w_f7     = w_instr[31:25];

  always_comb begin
    w_cls = '0;
    w_imm = '0;
    w_ill = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_cls[C_LUI] = 1'b1;
        w_imm = {w_instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        w_cls[C_AUIPC] = 1'b1;
        w_imm = {w_instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        w_cls[C_JAL] = 1'b1;
        w_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                 w_instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        w_cls[C_JALR] = 1'b1;
        w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
        w_ill = (w_f3 != 3'd0);
      end
      OPC_BRANCH: begin
        w_cls[C_BRANCH] = 1'b1;
        w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                 w_instr[11:8], 1'b0};
        w_ill = (w_f3 == 3'd2) || (w_f3 == 3'd3);
      end
      OPC_LOAD: begin
        w_cls[C_LOAD] = 1'b1;
        w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
        w_ill = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
      end
      OPC_STORE: begin
        w_cls[C_STORE] = 1'b1;
        w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
        w_ill = (w_f3 > 3'd2);
      end
      OPC_OPIMM: begin
        w_cls[C_OPIMM] = 1'b1;
        w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
        if (w_f3 == 3'd1)
          w_ill = (w_f7 != 7'h00);
        else if (w_f3 == 3'd5)
          w_ill = !((w_f7 == 7'h00) || (w_f7 == 7'h20));
      end
      OPC_OP: begin
        w_cls[C_OP] = 1'b1;
        case (w_f7)
          7'h00:   w_ill = 1'b0;
          7'h20:   w_ill = !((w_f3 == 3'd0) || (w_f3 == 3'd5));
          7'h01:   w_ill = !ENABLE_M;
          default: w_ill = 1'b1;
        endcase
      end
      OPC_MISCMEM: w_cls[C_MISCMEM] = 1'b1;
      OPC_SYSTEM: begin
        w_cls[C_SYSTEM] = 1'b1;
        w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
      end
      default: w_ill = 1'b1;
    endcase
    if (w_instr[1:0] != 2'b11)
      w_ill = 1'b1;
    if (w_ill)
      w_imm = '0;
    if (f2e_exc_start) begin
      w_cls = '0;
      w_ill = 1'b0;
      w_imm = '0;
    end
  end

  // Kill outranks load; a consume without a new load empties the slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
      r_exc   <= 1'b0;
      r_epc   <= '0;
      r_cause <= '0;
      r_priv  <= '0;
      r_cls   <= '0;
      r_rd    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_f3    <= '0;
      r_imm   <= '0;
      r_ill   <= 1'b0;
    end else if (e2d_kill) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_pc    <= f2e_pc;
      r_instr <= w_instr;
      r_exc   <= f2e_exc_start;
      r_epc   <= f2e_epc;
      r_cause <= f2e_cause;
      r_priv  <= f2e_exc_privilege;
      r_cls   <= w_cls;
      r_rd    <= w_instr[11:7];
      r_rs1   <= w_instr[19:15];
      r_rs2   <= w_instr[24:20];
      r_f3    <= w_f3;
      r_imm   <= w_imm;
      r_ill   <= w_ill;
    end else if (d2e_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign d2e_valid         = r_valid;
  assign d2e_pc            = r_pc;
  assign d2e_instr         = r_instr;
  assign d2e_exc_start     = r_exc;
  assign d2e_epc           = r_epc;
  assign d2e_cause         = r_cause;
  assign d2e_exc_privilege = r_priv;
  assign d2e_class         = r_cls;
  assign d2e_rd            = r_rd;
  assign d2e_rs1           = r_rs1;
  assign d2e_rs2           = r_rs2;
  assign d2e_funct3        = r_f3;
  assign d2e_imm           = r_imm;
  assign d2e_illegal       = r_ill;

endmodule
